// File: rtl/druaga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_pkg
//  Description : Shared definitions for the Druaga-family core. Holds the ROM
//                loader state encoding, download index numbers and the title
//                numbers that the DIP-switch mux also decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package druaga_pkg;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } loader_state_t;

    // Width of the HPS download byte address
    localparam int c_DL_AW = 25;

    // Download indices used by the menu
    localparam logic [7:0] c_ROM_INDEX = 8'd0;
    localparam logic [7:0] c_TNO_INDEX = 8'd1;

    // Title numbers; 0 means no title has been selected yet
    localparam logic [3:0] c_TNO_NONE    = 4'd0;
    localparam logic [3:0] c_TNO_DRUAGA  = 4'd1;
    localparam logic [3:0] c_TNO_MAPPY   = 4'd2;
    localparam logic [3:0] c_TNO_DIGDUG2 = 4'd3;
    localparam logic [3:0] c_TNO_MOTOS   = 4'd4;

    // A title byte is only meaningful when it names one of the known games;
    // the whole byte is checked so stray upper bits are not silently masked.
    function automatic logic is_valid_tno(input logic [7:0] value);
        return (value >= {4'd0, c_TNO_DRUAGA}) && (value <= {4'd0, c_TNO_MOTOS});
    endfunction

endpackage : druaga_pkg
`default_nettype wire

// File: rtl/druaga_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : druaga_rom_loader
//  Description : Bridges the HPS download stream to the core ROM-write port.
//                Registers and range-checks ROM bytes, captures the title
//                number, and holds the game core in reset until a complete
//                image has loaded plus a settle delay. Reports load status.
//  Revision    : 1.0 - initial release
// ============================================================================
module druaga_rom_loader
    import druaga_pkg::*;
#(
    parameter int         ROM_AW      = 17,
    parameter int         ROM_SIZE    = 2**17,
    parameter int         MIN_BYTES   = 65536,
    parameter int         HOLD_CYCLES = 255,
    parameter logic [7:0] ROM_INDEX   = c_ROM_INDEX,
    parameter logic [7:0] TNO_INDEX   = c_TNO_INDEX
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              DL_ACTIVE,
    input  logic              DL_WR,
    input  logic [7:0]        DL_INDEX,
    input  logic [24:0]       DL_ADDR,
    input  logic [7:0]        DL_DATA,
    output logic [ROM_AW-1:0] ROMAD,
    output logic [7:0]        ROMDT,
    output logic              ROMEN,
    output logic [3:0]        TNO,
    output logic              CORE_RST,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    // Hold counter only needs to reach HOLD_CYCLES-1
    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

    // One extra bit so ROM_SIZE / MIN_BYTES up to 2**25 compare cleanly
    localparam logic [c_DL_AW:0]   c_ROM_SIZE_EXT = (c_DL_AW + 1)'(ROM_SIZE);
    localparam logic [c_DL_AW:0]   c_MIN_EXT      = (c_DL_AW + 1)'(MIN_BYTES);
    localparam logic [c_DL_AW-1:0] c_CNT_MAX      = {c_DL_AW{1'b1}};

    loader_state_t       r_state;
    loader_state_t       w_state_next;
    logic                r_dl_active_d;
    logic [c_DL_AW-1:0]  r_byte_cnt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_load_err;
    logic [3:0]          r_tno;
    logic [ROM_AW-1:0]   r_romad;
    logic [7:0]          r_romdt;
    logic                r_romen;

    logic                w_rise;
    logic                w_fall;
    logic                w_in_load;
    logic                w_rom_wr;
    logic                w_addr_ok;
    logic                w_rom_acc;
    logic                w_rom_bad;
    logic                w_tno_wr;
    logic                w_tno_ok;
    logic [c_DL_AW-1:0]  w_cnt_upd;
    logic                w_err_upd;
    logic                w_load_good;

    // DL_ACTIVE edges against a one-cycle delayed copy
    assign w_rise = DL_ACTIVE & ~r_dl_active_d;
    assign w_fall = ~DL_ACTIVE & r_dl_active_d;

    // Byte classification; strobes are only honoured while loading
    assign w_in_load = (r_state == LOAD);
    assign w_rom_wr  = w_in_load & DL_WR & (DL_INDEX == ROM_INDEX);
    assign w_addr_ok = ({1'b0, DL_ADDR} < c_ROM_SIZE_EXT);
    assign w_rom_acc = w_rom_wr & w_addr_ok;
    assign w_rom_bad = w_rom_wr & ~w_addr_ok;
    assign w_tno_wr  = w_in_load & DL_WR & (DL_INDEX == TNO_INDEX);
    assign w_tno_ok  = is_valid_tno(DL_DATA);

    // Count and error status including the current byte, so a strobe landing
    // on the DL_ACTIVE fall cycle still takes part in the completeness test.
    assign w_cnt_upd   = (w_rom_acc && (r_byte_cnt != c_CNT_MAX)) ? r_byte_cnt + 1'b1
                                                                  : r_byte_cnt;
    assign w_err_upd   = r_load_err | w_rom_bad | (w_tno_wr & ~w_tno_ok);
    assign w_load_good = ({1'b0, w_cnt_upd} >= c_MIN_EXT) & ~w_err_upd;

    // State register
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a DL_ACTIVE rise restarts loading from any state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_next = LOAD;
            end
            LOAD: begin
                if (w_rise)      w_state_next = LOAD;
                else if (w_fall) w_state_next = w_load_good ? SETTLE : FAIL;
            end
            SETTLE: begin
                if (w_rise)                  w_state_next = LOAD;
                else if (r_hold_cnt == '0)   w_state_next = RUN;
            end
            RUN: begin
                if (w_rise) w_state_next = LOAD;
            end
            FAIL: begin
                if (w_rise) w_state_next = LOAD;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // DL_ACTIVE delay line for edge detection
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_dl_active_d <= 1'b0;
        end else begin
            r_dl_active_d <= DL_ACTIVE;
        end
    end

    // Registered ROM write port: one-cycle latency, pulse per accepted byte
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_romen <= 1'b0;
            r_romad <= '0;
            r_romdt <= '0;
        end else begin
            r_romen <= w_rom_acc;
            if (w_rom_acc) begin
                r_romad <= DL_ADDR[ROM_AW-1:0];
                r_romdt <= DL_DATA;
            end
        end
    end

    // Accepted-byte counter, cleared whenever a new load begins
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_byte_cnt <= '0;
        end else if (w_rise) begin
            r_byte_cnt <= '0;
        end else if (w_in_load) begin
            r_byte_cnt <= w_cnt_upd;
        end
    end

    // Sticky load error: cleared on load start, forced while heading to FAIL
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_load_err <= 1'b0;
        end else if (w_rise) begin
            r_load_err <= 1'b0;
        end else if (w_state_next == FAIL) begin
            r_load_err <= 1'b1;
        end else if (w_in_load) begin
            r_load_err <= w_err_upd;
        end
    end

    // Title number; survives reloads that do not rewrite it
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_tno <= c_TNO_NONE;
        end else if (w_tno_wr) begin
            r_tno <= w_tno_ok ? DL_DATA[3:0] : c_TNO_NONE;
        end
    end

    // Settle down-counter: loaded on SETTLE entry, counts to zero inside it
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            r_hold_cnt <= '0;
        end else if ((w_state_next == SETTLE) && (r_state != SETTLE)) begin
            r_hold_cnt <= c_HOLD_LOAD;
        end else if ((r_state == SETTLE) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    // Status outputs decode straight from the state register so CORE_RST
    // rises on the very edge that leaves RUN.
    assign ROMAD     = r_romad;
    assign ROMDT     = r_romdt;
    assign ROMEN     = r_romen;
    assign TNO       = r_tno;
    assign CORE_RST  = (r_state != RUN);
    assign LOAD_DONE = (r_state == RUN);
    assign LOAD_ERR  = r_load_err;

endmodule : druaga_rom_loader
`default_nettype wire

// File: tb/tb_druaga_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_druaga_rom_loader
//  Description : Directed self-checking bench for druaga_rom_loader. The
//                completeness threshold is lowered to keep loads short; ROM
//                size and settle length stay at their defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_druaga_rom_loader;

    localparam int TB_MIN_BYTES = 2048;
    localparam int TB_HOLD      = 255;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b0;
    logic        DL_ACTIVE = 1'b0;
    logic        DL_WR = 1'b0;
    logic [7:0]  DL_INDEX = 8'd0;
    logic [24:0] DL_ADDR = 25'd0;
    logic [7:0]  DL_DATA = 8'd0;
    logic [16:0] ROMAD;
    logic [7:0]  ROMDT;
    logic        ROMEN;
    logic [3:0]  TNO;
    logic        CORE_RST;
    logic        LOAD_DONE;
    logic        LOAD_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    druaga_rom_loader #(
        .MIN_BYTES (TB_MIN_BYTES)
    ) dut (
        .MCLK      (MCLK),
        .RESET     (RESET),
        .DL_ACTIVE (DL_ACTIVE),
        .DL_WR     (DL_WR),
        .DL_INDEX  (DL_INDEX),
        .DL_ADDR   (DL_ADDR),
        .DL_DATA   (DL_DATA),
        .ROMAD     (ROMAD),
        .ROMDT     (ROMDT),
        .ROMEN     (ROMEN),
        .TNO       (TNO),
        .CORE_RST  (CORE_RST),
        .LOAD_DONE (LOAD_DONE),
        .LOAD_ERR  (LOAD_ERR)
    );

    always #5 MCLK = ~MCLK;

    // Byte pattern derived from the address
    function automatic logic [7:0] pat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic rise_active();
        @(negedge MCLK); DL_ACTIVE = 1'b1; DL_WR = 1'b0;
        @(posedge MCLK); #1;
    endtask

    task automatic fall_active();
        @(negedge MCLK); DL_ACTIVE = 1'b0; DL_WR = 1'b0;
        @(posedge MCLK); #1;
    endtask

    task automatic end_wr();
        @(negedge MCLK); DL_WR = 1'b0;
        @(posedge MCLK); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    // Back-to-back index-0 bytes; each must appear on the ROM port one edge later
    task automatic stream(input int n, input int base, output int bad, output int first_bad);
        logic [24:0] a;
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            a = 25'(base + i);
            @(negedge MCLK);
            DL_WR = 1'b1; DL_INDEX = 8'd0; DL_ADDR = a; DL_DATA = pat(a);
            @(posedge MCLK); #1;
            if (ROMEN !== 1'b1 || ROMAD !== a[16:0] || ROMDT !== pat(a)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
    endtask

    task automatic write_tno(input logic [7:0] v);
        @(negedge MCLK);
        DL_WR = 1'b1; DL_INDEX = 8'd1; DL_ADDR = 25'd0; DL_DATA = v;
        @(posedge MCLK); #1;
    endtask

    // Counts observations with CORE_RST high, starting right after the exit edge
    task automatic wait_run(output int high_cycles);
        high_cycles = 0;
        for (int k = 0; k < 2000 && CORE_RST === 1'b1; k++) begin
            high_cycles++;
            @(posedge MCLK); #1;
        end
    endtask

    task automatic test_reset();
        #2 RESET = 1'b1;
        idle_cycles(2);
        n_tests++; if (ROMAD !== 17'd0)   begin n_fail++; $display("FAIL reset_romad: got %0h want 0", ROMAD); end
        n_tests++; if (ROMDT !== 8'd0)    begin n_fail++; $display("FAIL reset_romdt: got %0h want 0", ROMDT); end
        n_tests++; if (ROMEN !== 1'b0)    begin n_fail++; $display("FAIL reset_romen: got %b want 0", ROMEN); end
        n_tests++; if (TNO !== 4'd0)      begin n_fail++; $display("FAIL reset_tno: got %0d want 0", TNO); end
        n_tests++; if (CORE_RST !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", CORE_RST); end
        n_tests++; if (LOAD_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_load_done: got %b want 0", LOAD_DONE); end
        n_tests++; if (LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_load_err: got %b want 0", LOAD_ERR); end
        @(negedge MCLK); RESET = 1'b0;
        idle_cycles(3);
        n_tests++; if (CORE_RST !== 1'b1) begin n_fail++; $display("FAIL idle_core_rst: got %b want 1", CORE_RST); end
    endtask

    task automatic test_full_load();
        int bad, fb, hc;
        rise_active();
        n_tests++; if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0) begin n_fail++; $display("FAIL load_entry: core_rst=%b done=%b want 1/0", CORE_RST, LOAD_DONE); end
        stream(4096, 0, bad, fb);
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL full_stream: %0d bad bytes, first at %0d, want 0", bad, fb); end
        end_wr();
        n_tests++; if (ROMEN !== 1'b0) begin n_fail++; $display("FAIL romen_pulse_width: got %b want 0", ROMEN); end
        fall_active();
        wait_run(hc);
        n_tests++; if (hc !== TB_HOLD) begin n_fail++; $display("FAIL settle_length: got %0d want %0d", hc, TB_HOLD); end
        n_tests++; if (LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL run_status: done=%b err=%b want 1/0", LOAD_DONE, LOAD_ERR); end
    endtask

    task automatic test_tno();
        int bad, fb;
        rise_active();
        write_tno(8'h02);
        n_tests++; if (TNO !== 4'd2) begin n_fail++; $display("FAIL tno_valid: got %0d want 2", TNO); end
        n_tests++; if (ROMEN !== 1'b0 || LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL tno_side_effects: romen=%b err=%b want 0/0", ROMEN, LOAD_ERR); end
        write_tno(8'h07);
        n_tests++; if (TNO !== 4'd0 || LOAD_ERR !== 1'b1) begin n_fail++; $display("FAIL tno_invalid: tno=%0d err=%b want 0/1", TNO, LOAD_ERR); end
        stream(TB_MIN_BYTES, 0, bad, fb);
        fall_active();
        idle_cycles(300);
        n_tests++; if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b1) begin n_fail++; $display("FAIL tno_fail_state: rst=%b done=%b err=%b want 1/0/1", CORE_RST, LOAD_DONE, LOAD_ERR); end
    endtask

    task automatic test_short_load();
        int bad, fb, hc;
        rise_active();
        n_tests++; if (LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_rise: got %b want 0", LOAD_ERR); end
        stream(1000, 0, bad, fb);
        fall_active();
        idle_cycles(300);
        n_tests++; if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b1) begin n_fail++; $display("FAIL short_fail: rst=%b done=%b err=%b want 1/0/1", CORE_RST, LOAD_DONE, LOAD_ERR); end
        rise_active();
        stream(TB_MIN_BYTES, 0, bad, fb);
        fall_active();
        wait_run(hc);
        n_tests++; if (hc !== TB_HOLD || LOAD_DONE !== 1'b1 || LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL recover_run: hold=%0d done=%b err=%b want %0d/1/0", hc, LOAD_DONE, LOAD_ERR, TB_HOLD); end
    endtask

    task automatic test_threshold();
        int bad, fb, hc;
        rise_active();
        stream(TB_MIN_BYTES - 1, 0, bad, fb);
        fall_active();
        idle_cycles(300);
        n_tests++; if (LOAD_ERR !== 1'b1 || CORE_RST !== 1'b1) begin n_fail++; $display("FAIL one_short: err=%b rst=%b want 1/1", LOAD_ERR, CORE_RST); end
        rise_active();
        stream(TB_MIN_BYTES - 1, 0, bad, fb);
        // last byte arrives in the same cycle DL_ACTIVE falls
        @(negedge MCLK);
        DL_ACTIVE = 1'b0; DL_WR = 1'b1; DL_INDEX = 8'd0;
        DL_ADDR = 25'(TB_MIN_BYTES - 1); DL_DATA = pat(25'(TB_MIN_BYTES - 1));
        @(posedge MCLK); #1;
        n_tests++; if (ROMEN !== 1'b1 || ROMAD !== 17'(TB_MIN_BYTES - 1)) begin n_fail++; $display("FAIL fall_cycle_byte: romen=%b addr=%0h want 1/%0h", ROMEN, ROMAD, TB_MIN_BYTES - 1); end
        wait_run(hc);
        n_tests++; if (hc !== TB_HOLD || LOAD_DONE !== 1'b1) begin n_fail++; $display("FAIL fall_cycle_counted: hold=%0d done=%b want %0d/1", hc, LOAD_DONE, TB_HOLD); end
        n_tests++; if (ROMEN !== 1'b0) begin n_fail++; $display("FAIL wr_outside_load: romen=%b want 0", ROMEN); end
        @(negedge MCLK); DL_WR = 1'b0;
    endtask

    task automatic test_out_of_range();
        int bad, fb;
        rise_active();
        stream(TB_MIN_BYTES, 0, bad, fb);
        stream(1, 25'h1FFFF, bad, fb);
        n_tests++; if (bad !== 0 || LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL last_rom_addr: bad=%0d err=%b want 0/0", bad, LOAD_ERR); end
        @(negedge MCLK);
        DL_WR = 1'b1; DL_INDEX = 8'd0; DL_ADDR = 25'h20000; DL_DATA = 8'hA5;
        @(posedge MCLK); #1;
        n_tests++; if (ROMEN !== 1'b0 || LOAD_ERR !== 1'b1) begin n_fail++; $display("FAIL out_of_range: romen=%b err=%b want 0/1", ROMEN, LOAD_ERR); end
        fall_active();
        idle_cycles(10);
        n_tests++; if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b1) begin n_fail++; $display("FAIL range_fail_state: rst=%b done=%b err=%b want 1/0/1", CORE_RST, LOAD_DONE, LOAD_ERR); end
    endtask

    task automatic test_reload_from_run();
        int bad, fb, hc;
        rise_active();
        write_tno(8'h04);
        stream(TB_MIN_BYTES, 0, bad, fb);
        fall_active();
        wait_run(hc);
        n_tests++; if (TNO !== 4'd4 || LOAD_DONE !== 1'b1 || CORE_RST !== 1'b0) begin n_fail++; $display("FAIL motos_run: tno=%0d done=%b rst=%b want 4/1/0", TNO, LOAD_DONE, CORE_RST); end
        rise_active();
        n_tests++; if (CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0) begin n_fail++; $display("FAIL reload_core_rst: rst=%b done=%b want 1/0", CORE_RST, LOAD_DONE); end
        stream(TB_MIN_BYTES, 16, bad, fb);
        fall_active();
        wait_run(hc);
        n_tests++; if (hc !== TB_HOLD || LOAD_DONE !== 1'b1 || TNO !== 4'd4) begin n_fail++; $display("FAIL reload_keeps_tno: hold=%0d done=%b tno=%0d want %0d/1/4", hc, LOAD_DONE, TNO, TB_HOLD); end
    endtask

    task automatic test_reset_mid_load();
        int bad, fb, hc;
        rise_active();
        write_tno(8'h03);
        stream(1000, 0, bad, fb);
        #1 RESET = 1'b1;
        #1;
        n_tests++; if (ROMEN !== 1'b0 || ROMAD !== 17'd0 || ROMDT !== 8'd0) begin n_fail++; $display("FAIL midreset_rom: en=%b ad=%0h dt=%0h want 0/0/0", ROMEN, ROMAD, ROMDT); end
        n_tests++; if (TNO !== 4'd0 || CORE_RST !== 1'b1 || LOAD_DONE !== 1'b0 || LOAD_ERR !== 1'b0) begin n_fail++; $display("FAIL midreset_status: tno=%0d rst=%b done=%b err=%b want 0/1/0/0", TNO, CORE_RST, LOAD_DONE, LOAD_ERR); end
        @(negedge MCLK); DL_ACTIVE = 1'b0; DL_WR = 1'b0;
        @(negedge MCLK); RESET = 1'b0;
        rise_active();
        stream(TB_MIN_BYTES, 0, bad, fb);
        fall_active();
        wait_run(hc);
        n_tests++; if (hc !== TB_HOLD || LOAD_DONE !== 1'b1 || TNO !== 4'd0) begin n_fail++; $display("FAIL post_reset_load: hold=%0d done=%b tno=%0d want %0d/1/0", hc, LOAD_DONE, TNO, TB_HOLD); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_tno();
        test_short_load();
        test_threshold();
        test_out_of_range();
        test_reload_from_run();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_druaga_rom_loader
`default_nettype wire
